// File: rtl/fp16_pkg.sv
// fp16_pkg: shared field widths, the stage-1 register layout and a
// significand helper for the binary16 add-align pipeline.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int SIG_W  = 11;

  // Stage-1 register. The sign is stored already resolved, so an
  // equal-magnitude subtract yields +0.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;   // already aligned to exp
    logic             if_sub;
  } s1_t;

  // {hidden, frac}; exp 0 carries no hidden bit.
  function automatic logic [SIG_W-1:0] sig_of(input logic [15:0] x);
    return {|x[14:10], x[9:0]};
  endfunction

endpackage

// File: rtl/fp16_mag_swap.sv
// fp16_mag_swap: combinational magnitude compare and operand swap.
// Ports:
//   op_a, op_b : binary16 operands
//   sign_l     : sign of the larger-magnitude operand (L)
//   exp_l      : biased exponent of L
//   sig_l      : significand of L
//   sig_s      : significand of the smaller operand S (unshifted)
//   shamt      : exp_l - exp_s, the right shift that aligns S to L
//   mag_eq     : |A| == |B|
//   if_sub     : operand signs differ
module fp16_mag_swap
  import fp16_pkg::*;
(
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             sign_l,
  output logic [EXP_W-1:0] exp_l,
  output logic [SIG_W-1:0] sig_l,
  output logic [SIG_W-1:0] sig_s,
  output logic [EXP_W-1:0] shamt,
  output logic             mag_eq,
  output logic             if_sub
);

  logic a_ge_b;

  always_comb begin
    // {exp,frac} orders like the magnitude, so a plain compare works.
    a_ge_b = (op_a[14:0] >= op_b[14:0]);
    mag_eq = (op_a[14:0] == op_b[14:0]);
    if_sub = op_a[15] ^ op_b[15];
    if (a_ge_b) begin
      sign_l = op_a[15];
      exp_l  = op_a[14:10];
      sig_l  = sig_of(op_a);
      sig_s  = sig_of(op_b);
      shamt  = op_a[14:10] - op_b[14:10];
    end else begin
      sign_l = op_b[15];
      exp_l  = op_b[14:10];
      sig_l  = sig_of(op_b);
      sig_s  = sig_of(op_a);
      shamt  = op_b[14:10] - op_a[14:10];
    end
  end

endmodule

// File: rtl/fp16_add_align.sv
// fp16_add_align: two-stage binary16 align-and-add front end. Stage 1
// swaps the operands so L >= S and aligns S; stage 2 adds or subtracts
// the significands. Valid/ready on both sides; one result per cycle.
// Optional feature macro: FP16_ALIGN_ZERO_BYPASS_EN (a +/-0 operand
// passes the other operand straight through).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_ready  : operand handshake (in_ready is combinational)
//   op_a, op_b          : binary16 operands
//   out_valid,out_ready : result handshake
//   sign, exponent      : result sign, exponent of the larger operand
//   mantissa_add        : sum/difference bits [10:0]
//   if_carray           : sum bit 11
//   if_sub              : effective subtract
module fp16_add_align
  import fp16_pkg::*;
#(
  parameter int PIPE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [SIG_W-1:0] mantissa_add,
  output logic             if_carray,
  output logic             if_sub
);

  if (PIPE_DEPTH != 2) begin : g_depth_check
    $error("fp16_add_align: PIPE_DEPTH must be 2");
  end

  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(SIG_W);

  logic             sw_sign_l;
  logic [EXP_W-1:0] sw_exp_l;
  logic [SIG_W-1:0] sw_sig_l;
  logic [SIG_W-1:0] sw_sig_s;
  logic [EXP_W-1:0] sw_shamt;
  logic             sw_mag_eq;
  logic             sw_if_sub;

  fp16_mag_swap u_swap (
    .op_a   (op_a),
    .op_b   (op_b),
    .sign_l (sw_sign_l),
    .exp_l  (sw_exp_l),
    .sig_l  (sw_sig_l),
    .sig_s  (sw_sig_s),
    .shamt  (sw_shamt),
    .mag_eq (sw_mag_eq),
    .if_sub (sw_if_sub)
  );

  s1_t  s1_next;
  s1_t  s1;
  logic s1_valid;
  logic s2_load;

`ifdef FP16_ALIGN_ZERO_BYPASS_EN
  logic a_zero;
  logic b_zero;
`endif

  always_comb begin
    s1_next.exp    = sw_exp_l;
    s1_next.sig_l  = sw_sig_l;
    s1_next.if_sub = sw_if_sub;
    s1_next.sig_s  = (sw_shamt >= SH_MAX) ? '0 : (sw_sig_s >> sw_shamt);
    s1_next.sign   = (sw_if_sub && sw_mag_eq) ? 1'b0 : sw_sign_l;
`ifdef FP16_ALIGN_ZERO_BYPASS_EN
    a_zero = (op_a[14:0] == 15'd0);
    b_zero = (op_b[14:0] == 15'd0);
    // The zero operand is never L unless both are zero, so L already
    // holds the operand to pass through.
    if (a_zero || b_zero) begin
      s1_next.if_sub = 1'b0;
      s1_next.sig_s  = '0;
      if (a_zero && b_zero) s1_next.sign = op_a[15] & op_b[15];
      else if (a_zero)      s1_next.sign = op_b[15];
      else                  s1_next.sign = op_a[15];
    end
`endif
  end

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // in_ready implies s1 is empty or draining this cycle, so it can
  // always take the incoming pair (or empty) without losing anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1 <= s1_next;
    end
  end

  logic [SIG_W:0] sum;

  always_comb begin
    if (s1.if_sub) sum = {1'b0, s1.sig_l} - {1'b0, s1.sig_s};
    else           sum = {1'b0, s1.sig_l} + {1'b0, s1.sig_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      sign         <= 1'b0;
      exponent     <= '0;
      mantissa_add <= '0;
      if_carray    <= 1'b0;
      if_sub       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign         <= s1.sign;
        exponent     <= s1.exp;
        mantissa_add <= sum[SIG_W-1:0];
        if_carray    <= sum[SIG_W];
        if_sub       <= s1.if_sub;
      end
    end
  end

endmodule

// File: tb/tb_fp16_add_align.sv
module tb_fp16_add_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic        sign;
  logic [4:0]  exponent;
  logic [10:0] mantissa_add;
  logic        if_carray;
  logic        if_sub;

  fp16_add_align #(.PIPE_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sign         (sign),
    .exponent     (exponent),
    .mantissa_add (mantissa_add),
    .if_carray    (if_carray),
    .if_sub       (if_sub)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [4:0]  e;
    logic [10:0] m;
    logic        c;
    logic        u;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
    bit   lat;
  } exp_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  exp_t sbq [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input string detail);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [18:0] pack_v(input vec_t v);
    return {v.s, v.e, v.m, v.c, v.u};
  endfunction

  logic [18:0] cur;
  assign cur = {sign, exponent, mantissa_add, if_carray, if_sub};

  // Monitor: compares on every output transfer, and checks that a
  // stalled output holds its fields.
  bit          stalled = 1'b0;
  logic [18:0] prev_f;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("hold", cur == prev_f,
              $sformatf("got %05h required %05h", cur, prev_f));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", 1'b0, $sformatf("got %05h required none", cur));
        end else begin
          e = sbq.pop_front();
          check($sformatf("vec_%04h_%04h", e.v.a, e.v.b), cur == pack_v(e.v),
                $sformatf("got s/e/m/c/u %0b/%0d/%03h/%0b/%0b required %0b/%0d/%03h/%0b/%0b",
                          sign, exponent, mantissa_add, if_carray, if_sub,
                          e.v.s, e.v.e, e.v.m, e.v.c, e.v.u));
          if (e.lat)
            check("latency", (cyc - e.acc + 1) == 2,
                  $sformatf("got %0d cycles required 2", cyc - e.acc + 1));
        end
      end
      stalled = out_valid && !out_ready;
      prev_f  = cur;
    end
  end

  task automatic send(input vec_t v, input bit lat);
    bit done = 1'b0;
    op_a     = v.a;
    op_b     = v.b;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back('{v: v, acc: cyc + 1, lat: lat});
        n_acc++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 1'b0, "got no in_ready required accept within 100 cycles");
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sbq.size() > 0; t++) @(posedge clk);
    if (sbq.size() > 0)
      check("drain_timeout", 1'b0, $sformatf("got %0d pending required 0", sbq.size()));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish by 200000");
    $fatal(1);
  end

  initial begin
    int base;
    tbl[0]  = '{16'h3C00, 16'h3C00, 1'b0, 5'd15, 11'h000, 1'b1, 1'b0};
    tbl[1]  = '{16'h3C00, 16'hB800, 1'b0, 5'd15, 11'h200, 1'b0, 1'b1};
    tbl[2]  = '{16'h3C00, 16'hBC00, 1'b0, 5'd15, 11'h000, 1'b0, 1'b1};
    tbl[3]  = '{16'h3C00, 16'h0001, 1'b0, 5'd15, 11'h400, 1'b0, 1'b0};
    tbl[4]  = '{16'hBC00, 16'h3C00, 1'b0, 5'd15, 11'h000, 1'b0, 1'b1};
    tbl[5]  = '{16'h4000, 16'h3C00, 1'b0, 5'd16, 11'h600, 1'b0, 1'b0};
    tbl[6]  = '{16'h3C00, 16'h1400, 1'b0, 5'd15, 11'h401, 1'b0, 1'b0};
    tbl[7]  = '{16'h3C00, 16'h1000, 1'b0, 5'd15, 11'h400, 1'b0, 1'b0};
    tbl[8]  = '{16'h0001, 16'h0001, 1'b0, 5'd0,  11'h002, 1'b0, 1'b0};
    tbl[9]  = '{16'hC000, 16'h3C00, 1'b1, 5'd16, 11'h200, 1'b0, 1'b1};
    tbl[10] = '{16'h7C00, 16'h7C00, 1'b0, 5'd31, 11'h000, 1'b1, 1'b0};
    tbl[11] = '{16'h3E00, 16'h3E00, 1'b0, 5'd15, 11'h400, 1'b1, 1'b0};
    tbl[12] = '{16'h3C00, 16'hB7FF, 1'b0, 5'd15, 11'h201, 1'b0, 1'b1};
`ifdef FP16_ALIGN_ZERO_BYPASS_EN
    tbl[13] = '{16'h0000, 16'h8000, 1'b0, 5'd0,  11'h000, 1'b0, 1'b0};
    tbl[14] = '{16'h8000, 16'h3C00, 1'b0, 5'd15, 11'h400, 1'b0, 1'b0};
`else
    tbl[13] = '{16'h0000, 16'h8000, 1'b0, 5'd0,  11'h000, 1'b0, 1'b1};
    tbl[14] = '{16'h8000, 16'h3C00, 1'b0, 5'd15, 11'h400, 1'b0, 1'b1};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid == 1'b0, $sformatf("got %0b required 0", out_valid));
    check("reset_in_ready", in_ready == 1'b1, $sformatf("got %0b required 1", in_ready));
    check("reset_fields", cur == 19'd0, $sformatf("got %05h required 00000", cur));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", in_ready == 1'b1, $sformatf("got %0b required 1", in_ready));

    // Directed vectors, back to back, no output stall
    for (int i = 0; i < NV; i++) send(tbl[i], 1'b1);
    drain();

    // Burst of 8 with the output stalled for 3 cycles
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 8; i++) send(tbl[i], 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready", in_ready == 1'b0, $sformatf("got %0b required 0", in_ready));
        check("stall_accepts", (n_acc - base) == 2, $sformatf("got %0d required 2", n_acc - base));
        out_ready = 1'b1;
      end
    join
    drain();
    check("burst_count", (n_acc - base) == 8, $sformatf("got %0d required 8", n_acc - base));

    // Reset with two pairs in flight
    send(tbl[1], 1'b0);
    send(tbl[5], 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid == 1'b0, $sformatf("got %0b required 0", out_valid));
    check("midrst_in_ready", in_ready == 1'b1, $sformatf("got %0b required 1", in_ready));
    check("midrst_fields", cur == 19'd0, $sformatf("got %05h required 00000", cur));
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_stale", out_valid == 1'b0, $sformatf("got %0b required 0", out_valid));
    send(tbl[9], 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
